// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle.
// Carries the core-side request/response handshake and the data-memory port.
//   req_*  : one load/store request (valid/ready), byte address, right-aligned store data
//   resp_* : one-cycle response strobe with extended load data and error flag
//   mem_*  : word-wide data memory (async read via mem_dout, sync write at posedge)
// slave  : the load/store unit side
// master : the core + memory side (driver of requests, provider of mem_dout)
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr, mem_din, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr, mem_din, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: initiator side of the data-memory interface.
// Takes one request at a time, checks it, then walks IDLE -> [RD] -> [WR] -> RESP.
// Sub-word stores are read-modify-write (RD captures the word, WR writes it back
// with the addressed lane replaced). Loads are extended from the captured word in RESP.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high; returns to IDLE and clears all registers
//   bus   : load_store_unit_if.slave (request, response and memory signals)
// Params:
//   DMEM_BYTES : data memory size; addr >= DMEM_BYTES is rejected
module load_store_unit #(
  parameter int DMEM_BYTES = 65536
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [32:0] DMEM_LIM = 33'(DMEM_BYTES);

  state_t      state, state_nxt;
  logic        wr_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, data_q;

  logic        req_err;
  logic        legal_f3;
  logic [31:0] word_addr;
  logic [31:0] merged;
  logic [31:0] shifted;
  logic [31:0] ld_data;

  // Request check, evaluated on the live request while IDLE.
  always_comb begin
    legal_f3 = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
               (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
               (bus.req_funct3 == 3'b101);
    req_err  = !legal_f3 ||
               (bus.req_write && bus.req_funct3[2]) ||
               ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) ||
               ({1'b0, bus.req_addr} >= DMEM_LIM);
  end

  assign word_addr = {addr_q[31:2], 2'b00};

  // Store data: full word for SW, otherwise the captured word with one lane replaced.
  always_comb begin
    merged = data_q;
    case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Load extraction; halfword addresses are even, so the byte shift also aligns halves.
  always_comb begin
    shifted = data_q >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {24'h0, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_data = {16'h0, shifted[15:0]};
      default: ld_data = data_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        wr_q    <= bus.req_write;
        err_q   <= req_err;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == RD) data_q <= bus.mem_dout;
    end
  end

  // Memory strobes decode straight from state, so a reset in RD/WR drops them at once.
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0;
    bus.resp_error = 1'b0;
    bus.mem_addr   = 32'h0;
    bus.mem_din    = 32'h0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)                                        state_nxt = RESP;
          else if (bus.req_write && bus.req_funct3 == 3'b010) state_nxt = WR;
          else                                                state_nxt = RD;
        end
      end
      RD: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = word_addr;
        state_nxt    = wr_q ? WR : RESP;
      end
      WR: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = word_addr;
        bus.mem_din   = merged;
        state_nxt     = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_error = err_q;
        bus.resp_rdata = (err_q || wr_q) ? 32'h0 : ld_data;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver pushes expected responses and
// expected memory writes; a negedge monitor pops and compares as the DUT produces them.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.DMEM_BYTES(65536)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory model: async read, write at posedge.
  logic [31:0] mem [0:16383] = '{default: 32'h0};
  assign bus.mem_dout = mem[bus.mem_addr[15:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[15:2]] <= bus.mem_din;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
  } wexp_t;

  exp_t  exp_q[$];
  wexp_t wexp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int n_resp = 0;
  logic [31:0] cur_waddr = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_read) begin
        rd_cnt++;
        chk("read addr", bus.mem_addr, cur_waddr);
      end
      if (bus.mem_write) begin
        wr_cnt++;
        if (wexp_q.size() == 0) chk("unexpected write", 32'd1, 32'd0);
        else begin
          wexp_t w;
          w = wexp_q.pop_front();
          chk("write addr", bus.mem_addr, w.addr);
          chk("write din", bus.mem_din, w.din);
        end
      end
      if (!bus.mem_read && !bus.mem_write) begin
        chk("idle addr", bus.mem_addr, 32'h0);
        chk("idle din", bus.mem_din, 32'h0);
      end
      if (bus.resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0) chk("unexpected resp", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp rdata", bus.resp_rdata, e.rdata);
          chk("resp error", {31'h0, bus.resp_error}, {31'h0, e.err});
          chk("resp latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Issue one request; called at a negedge.
  task automatic issue(input string nm, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat,
                       input int nrd, input int nwr, input logic [31:0] wdin);
    int r0, w0, n0, k;
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    if (k == 20) chk({nm, " ready timeout"}, 32'd1, 32'd0);
    r0 = rd_cnt; w0 = wr_cnt; n0 = n_resp;
    cur_waddr = {a[31:2], 2'b00};
    exp_q.push_back('{er, ee, cyc, lat});
    if (nwr != 0) wexp_q.push_back('{cur_waddr, wdin});
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 0;
    while (n_resp == n0 && k < 20) begin @(negedge clk); k++; end
    if (k == 20) chk({nm, " resp timeout"}, 32'd1, 32'd0);
    chk({nm, " reads"}, rd_cnt - r0, nrd);
    chk({nm, " writes"}, wr_cnt - w0, nwr);
  endtask

  initial begin
    int r, w;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    @(negedge clk);
    chk("reset req_ready", {31'h0, bus.req_ready}, 32'd1);
    chk("reset resp_valid", {31'h0, bus.resp_valid}, 32'd0);
    chk("reset resp_rdata", bus.resp_rdata, 32'h0);
    chk("reset resp_error", {31'h0, bus.resp_error}, 32'd0);
    chk("reset mem_read", {31'h0, bus.mem_read}, 32'd0);
    chk("reset mem_write", {31'h0, bus.mem_write}, 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    chk("reset mem_din", bus.mem_din, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    //    name     w     f3      addr           wdata          rdata          err lat rd wr din
    issue("SW",    1'b1, 3'b010, 32'h0000_0100, 32'h8765_43A1, 32'h0,         0, 2, 0, 1, 32'h8765_43A1);
    issue("LB",    1'b0, 3'b000, 32'h0000_0100, 32'h0,         32'hFFFF_FFA1, 0, 2, 1, 0, 32'h0);
    issue("LBU",   1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h0000_0087, 0, 2, 1, 0, 32'h0);
    issue("LH",    1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'hFFFF_8765, 0, 2, 1, 0, 32'h0);
    issue("LHU",   1'b0, 3'b101, 32'h0000_0100, 32'h0,         32'h0000_43A1, 0, 2, 1, 0, 32'h0);
    issue("LW",    1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h8765_43A1, 0, 2, 1, 0, 32'h0);
    issue("SB",    1'b1, 3'b000, 32'h0000_0101, 32'hFFFF_FF55, 32'h0,         0, 3, 1, 1, 32'h8765_55A1);
    issue("SH",    1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0,         0, 3, 1, 1, 32'h1234_55A1);
    issue("LW2",   1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h1234_55A1, 0, 2, 1, 0, 32'h0);
    issue("LB+",   1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h0000_0012, 0, 2, 1, 0, 32'h0);
    issue("LWmis", 1'b0, 3'b010, 32'h0000_0102, 32'h0,         32'h0,         1, 1, 0, 0, 32'h0);
    issue("LHmis", 1'b0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         1, 1, 0, 0, 32'h0);
    issue("F3ill", 1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         1, 1, 0, 0, 32'h0);
    issue("SBU",   1'b1, 3'b100, 32'h0000_0100, 32'h0000_00FF, 32'h0,         1, 1, 0, 0, 32'h0);
    issue("LWoor", 1'b0, 3'b010, 32'h0001_0000, 32'h0,         32'h0,         1, 1, 0, 0, 32'h0);
    issue("SWtop", 1'b1, 3'b010, 32'h0000_FFFC, 32'hCAFE_F00D, 32'h0,         0, 2, 0, 1, 32'hCAFE_F00D);
    issue("LWtop", 1'b0, 3'b010, 32'h0000_FFFC, 32'h0,         32'hCAFE_F00D, 0, 2, 1, 0, 32'h0);

    // Reset while the SB is in its read cycle: no write, no response.
    r = n_resp; w = wr_cnt;
    cur_waddr = 32'h0000_0100;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0000_0100;
    bus.req_wdata  = 32'h0000_00EE;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort in RD", {31'h0, bus.mem_read}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort mem_write", {31'h0, bus.mem_write}, 32'd0);
    chk("abort mem_read", {31'h0, bus.mem_read}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort req_ready", {31'h0, bus.req_ready}, 32'd1);
    chk("abort no resp", n_resp - r, 32'd0);
    chk("abort no write", wr_cnt - w, 32'd0);
    issue("LWpost", 1'b0, 3'b010, 32'h0000_0100, 32'h0,       32'h1234_55A1, 0, 2, 1, 0, 32'h0);

    repeat (4) @(negedge clk);
    chk("resp queue drained", exp_q.size(), 32'd0);
    chk("write queue drained", wexp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
